// File: rtl/bist_fail_log_pkg.sv
// Shared widths, depths and FSM encoding for the BIST fail logger.
package bist_fail_log_pkg;
  localparam int SRAM_ADDR_WIDTH = 8;
  localparam int SRAM_WORD_WIDTH = 4;
  localparam int FAIL_LOG_DEPTH  = 8;
  localparam int FAIL_CNT_WIDTH  = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOGGING = 2'd1,
    ST_DONE    = 2'd2
  } log_state_e;
endpackage

// File: rtl/bist_fail_log_if.sv
// Readout channel for logged fail entries.
// valid/ready: a transfer happens on a rising edge where rd_valid && rd_ready; the
// producer holds rd_addr/rd_data stable while rd_valid=1 and rd_ready=0.
interface bist_fail_log_if #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 4
);
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_data;

  modport master (output rd_valid, output rd_addr, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_addr, input rd_data, output rd_ready);
endinterface

// File: rtl/bist_fail_log_fail_fifo.sv
// Synchronous FIFO with flush; pointers carry one extra wrap bit so full/empty
// come straight from pointer comparison.
module fail_fifo #(
  parameter int DW    = 12,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_din,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_accept,
  output logic [DW-1:0] o_dout
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [DW-1:0] r_mem [DEPTH];
  logic          w_do_pop;
  logic          w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);
  assign o_accept  = w_do_push;
  assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/bist_fail_log.sv
// BIST fail logger: FIFO of failing accesses, saturating count, sticky overflow, verdict.
// Optional BIST_FAIL_DEDUP_EN suppresses pushes that repeat the last pushed address.
module bist_fail_log
  import bist_fail_log_pkg::*;
#(
  parameter int ADDR_W    = SRAM_ADDR_WIDTH,
  parameter int WORD_W    = SRAM_WORD_WIDTH,
  parameter int LOG_DEPTH = FAIL_LOG_DEPTH,
  parameter int CNT_W     = FAIL_CNT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_log,
  input  logic              bist_done,
  input  logic              fail,
  input  logic [ADDR_W-1:0] fail_addr,
  input  logic [WORD_W-1:0] fail_data,
  bist_fail_log_if.master   rd,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              overflow,
  output logic              result_valid,
  output logic              pass,
  output log_state_e        dbg_state
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  log_state_e         r_state;
  log_state_e         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_ovf;
  logic               w_ovf_nxt;
  logic               r_result_valid;
  logic               r_pass;
  logic               w_log_event;
  logic               w_dup;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic               w_enter_done;
  logic               w_full;
  logic               w_empty;
  logic               w_accept;
  logic [ADDR_W+WORD_W-1:0] w_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start_log) begin
      w_state_nxt = ST_LOGGING;
    end else if (r_state == ST_LOGGING && bist_done) begin
      w_state_nxt = ST_DONE;
    end
  end

  assign w_log_event  = fail && (r_state == ST_LOGGING) && !start_log;
  assign w_pop        = !w_empty && rd.rd_ready && !start_log;
  assign w_push       = w_log_event && !w_dup;
  assign w_drop       = w_push && w_full && !w_pop;
  assign w_cnt_nxt    = (w_log_event && r_cnt != CNT_MAX) ? r_cnt + 1'b1 : r_cnt;
  assign w_ovf_nxt    = r_ovf | w_drop;
  assign w_enter_done = (r_state == ST_LOGGING) && bist_done && !start_log;

`ifdef BIST_FAIL_DEDUP_EN
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_last_valid;

  assign w_dup = r_last_valid && (r_last_addr == fail_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_addr  <= '0;
      r_last_valid <= 1'b0;
    end else if (start_log) begin
      r_last_addr  <= '0;
      r_last_valid <= 1'b0;
    end else if (w_accept) begin
      r_last_addr  <= fail_addr;
      r_last_valid <= 1'b1;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  // The verdict uses the next-state count/overflow so a fail on the bist_done cycle counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt          <= '0;
      r_ovf          <= 1'b0;
      r_result_valid <= 1'b0;
      r_pass         <= 1'b0;
    end else if (start_log) begin
      r_cnt          <= '0;
      r_ovf          <= 1'b0;
      r_result_valid <= 1'b0;
      r_pass         <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;
      if (w_enter_done) begin
        r_result_valid <= 1'b1;
        r_pass         <= (w_cnt_nxt == '0) && !w_ovf_nxt;
      end
    end
  end

  fail_fifo #(
    .DW    (ADDR_W + WORD_W),
    .DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_flush  (start_log),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_din    ({fail_addr, fail_data}),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_accept (w_accept),
    .o_dout   (w_head)
  );

  assign rd.rd_valid  = !w_empty;
  assign rd.rd_addr   = w_head[ADDR_W+WORD_W-1:WORD_W];
  assign rd.rd_data   = w_head[WORD_W-1:0];
  assign fail_cnt     = r_cnt;
  assign overflow     = r_ovf;
  assign result_valid = r_result_valid;
  assign pass         = r_pass;
  assign dbg_state    = r_state;
endmodule
